// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package seq_divider_pkg;

    localparam int N_DEF = 12;
    localparam int CNT_W = $clog2(N_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        DONE_Z
    } state_e;

    // Iteration counter width for an arbitrary operand width.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/trial_subtractor.sv
// Combinational trial subtraction A - B formed as A + ~B + 1.
// Borrow is the inverted carry-out of the addition.
module trial_subtractor #(
    parameter int W = 13
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Diff,
    output logic         Borrow
);

    logic [W:0] sum;

    assign sum    = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
    assign Diff   = sum[W-1:0];
    assign Borrow = ~sum[W];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with a Start/Busy/Done handshake and results held until the next operation.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero
);

    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          done_q, done_d;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          borrow;
    logic          take_sub;

    assign shifted = {r_q, q_q[N-1]};

    trial_subtractor #(
        .W (N + 1)
    ) u_trial (
        .A      (shifted),
        .B      ({1'b0, d_q}),
        .Diff   (diff),
        .Borrow (borrow)
    );

    // Without a borrow diff < Divisor, so diff[N] is zero; the guard keeps R in range.
    assign take_sub = ~borrow & ~diff[N];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The Done pulse cycle also sits in IDLE; Start is not taken there.
                if (Start && !done_q) begin
                    q_d     = Dividend;
                    d_d     = Divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = (Divisor == '0) ? DONE_Z : RUN;
                end
            end
            RUN: begin
                if (take_sub) begin
                    r_d = diff[N-1:0];
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    r_d = shifted[N-1:0];
                    q_d = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                quot_d  = q_q;
                rem_d   = r_q;
                dz_d    = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DONE_Z: begin
                quot_d  = '1;
                rem_d   = q_q;
                dz_d    = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivByZero = dz_q;
    assign Done      = done_q;
    assign Busy      = (state_q == RUN);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model plus directed vectors.
module tb_seq_divider;

    localparam int N = 12;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         Start = 1'b0;
    logic [N-1:0] Dividend = '0;
    logic [N-1:0] Divisor = '0;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;

    seq_divider #(
        .N (N)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic results, release times counted in edges.
    int           edge_n = 0;
    int           busy_end = 0;
    int           done_edge = 0;
    int           acc_ready = 0;
    bit           pend = 1'b0;
    logic [N-1:0] pq = '0, pr = '0;
    logic         pz = 1'b0;
    logic [N-1:0] m_q = '0, m_r = '0;
    logic         m_z = 1'b0, m_busy = 1'b0, m_done = 1'b0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pend = 1'b0; m_q = '0; m_r = '0; m_z = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; acc_ready = 0; edge_n = 0;
        end else begin
            edge_n++;
            m_done = 1'b0;
            if (pend && edge_n == done_edge) begin
                m_q = pq; m_r = pr; m_z = pz; m_done = 1'b1; pend = 1'b0;
            end else if (!pend && edge_n >= acc_ready && Start === 1'b1) begin
                pend = 1'b1;
                if (Divisor == 0) begin
                    pq = '1; pr = Dividend; pz = 1'b1;
                    busy_end = edge_n; done_edge = edge_n + 1;
                end else begin
                    pq = Dividend / Divisor; pr = Dividend % Divisor; pz = 1'b0;
                    busy_end = edge_n + N; done_edge = edge_n + N + 1;
                end
                acc_ready = done_edge + 2;
            end
            m_busy = pend && (edge_n < busy_end);
        end
    end

    always @(negedge Clk) begin
        if (!Rst) begin
            check("busy", Busy, m_busy);
            check("done", Done, m_done);
            check("quotient", Quotient, m_q);
            check("remainder", Remainder, m_r);
            check("divbyzero", DivByZero, m_z);
            check("busy_and_done", Busy & Done, 0);
            if (Done === 1'b1) done_pulses++;
        end
    end

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge Clk);
        Dividend = a; Divisor = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = (Busy === 1'b1) ? 1 : 0;
        while (lat < 64) begin
            @(negedge Clk);
            lat++;
            if (Busy === 1'b1) busy_cycles++;
            if (Done === 1'b1) break;
        end
        check("done_seen", Done, 1);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int exp_q, input int exp_r, input int exp_z);
        int lat, bc, p0;
        p0 = done_pulses;
        start_op(a, b);
        wait_done(lat, bc);
        check("lit_quotient", Quotient, exp_q);
        check("lit_remainder", Remainder, exp_r);
        check("lit_divbyzero", DivByZero, exp_z);
        check("lit_latency", lat, (b == 0) ? 1 : N + 1);
        check("lit_busy_cycles", bc, (b == 0) ? 0 : N);
        repeat (2) @(negedge Clk);
        check("lit_one_done", done_pulses - p0, 1);
    endtask

    initial begin
        int lat, bc, p0;

        repeat (3) @(negedge Clk);
        check("rst_quotient", Quotient, 0);
        check("rst_remainder", Remainder, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_divbyzero", DivByZero, 0);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        run_op(12'd100, 12'd7, 14, 2, 0);
        run_op(12'd4095, 12'd1, 4095, 0, 0);
        run_op(12'd5, 12'd9, 0, 5, 0);
        run_op(12'd4095, 12'd4095, 1, 0, 0);
        run_op(12'd37, 12'd0, 4095, 37, 1);
        run_op(12'd100, 12'd7, 14, 2, 0);

        // Start and operand changes while busy are ignored.
        p0 = done_pulses;
        start_op(12'd100, 12'd7);
        repeat (3) @(negedge Clk);
        Dividend = 12'd50; Divisor = 12'd5; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Dividend = 12'd999; Divisor = 12'd0;
        wait_done(lat, bc);
        check("busy_start_quotient", Quotient, 14);
        check("busy_start_remainder", Remainder, 2);
        repeat (4) @(negedge Clk);
        check("busy_start_one_done", done_pulses - p0, 1);

        // Asynchronous reset between edges mid-operation.
        start_op(12'd100, 12'd7);
        repeat (6) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("arst_quotient", Quotient, 0);
        check("arst_remainder", Remainder, 0);
        check("arst_busy", Busy, 0);
        check("arst_done", Done, 0);
        check("arst_divbyzero", DivByZero, 0);
        p0 = done_pulses;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        repeat (20) @(negedge Clk);
        check("arst_no_done", done_pulses - p0, 0);
        run_op(12'd9, 12'd4, 2, 1, 0);

        // Back-to-back: Start held through the Done cycle, taken one cycle later.
        start_op(12'd200, 12'd13);
        wait_done(lat, bc);
        check("b2b_first_quotient", Quotient, 15);
        check("b2b_first_remainder", Remainder, 5);
        Dividend = 12'd1000; Divisor = 12'd33; Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        check("b2b_hold_quotient", Quotient, 15);
        check("b2b_hold_remainder", Remainder, 5);
        check("b2b_second_busy", Busy, 1);
        wait_done(lat, bc);
        check("b2b_second_quotient", Quotient, 30);
        check("b2b_second_remainder", Remainder, 10);
        repeat (3) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
